// File: rtl/ifq_pkg.sv
// Shared constants and the FIFO entry layout for the instruction prefetch queue.
package ifq_pkg;

  localparam int          IFQ_DEFAULT_DEPTH = 4;
  localparam logic [31:0] IFQ_RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] IFQ_NOP           = 32'h0000_0000;
  localparam int          INSTR_W           = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_incr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with flush; pointers carry an extra MSB to tell full from empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage needs no reset: the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: credit-limited fetch issue, response buffering, redirect flush.
// Optional performance counters are enabled by defining IFQ_PERF_EN.
module if_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
`ifdef IFQ_PERF_EN
  output logic [31:0] pc_incr,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_empty_cnt,
  output logic [31:0] perf_drop_cnt
`else
  output logic [31:0] pc_incr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [31:0]   pcq [DEPTH];
  logic [AW-1:0] pcq_wr_reg, pcq_wr_next;
  logic [AW-1:0] pcq_rd_reg, pcq_rd_next;

  logic          accept, dropping, push, pop;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  ifq_entry_t    push_entry, head_entry;

  assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign imem_req   = !rst && !redirect && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_reg;
  assign accept     = imem_req && imem_ready;

  // Responses still owed from before a redirect are swallowed here, ahead of the FIFO.
  assign dropping    = imem_rvalid && (drop_cnt_reg != '0);
  assign push        = imem_rvalid && !dropping && !redirect;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && id_ready && !redirect;

  assign push_entry.instr   = imem_rdata;
  assign push_entry.pc_incr = pcq[pcq_rd_reg] + 32'd4;

  ifq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ifq_entry_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr   = instr_valid ? head_entry.instr   : IFQ_NOP;
  assign pc_incr = instr_valid ? head_entry.pc_incr : 32'h0;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rvalid);
    drop_cnt_next    = drop_cnt_reg;
    pcq_wr_next      = pcq_wr_reg;
    pcq_rd_next      = pcq_rd_reg;
    if (redirect) begin
      // Every response still in flight after this edge belongs to the old path.
      fetch_pc_next = redirect_pc;
      drop_cnt_next = outstanding_reg - CW'(imem_rvalid);
      pcq_wr_next   = '0;
      pcq_rd_next   = '0;
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        pcq_wr_next   = pcq_wr_reg + 1'b1;
      end
      if (dropping) drop_cnt_next = drop_cnt_reg - 1'b1;
      if (push)     pcq_rd_next   = pcq_rd_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      pcq_wr_reg      <= '0;
      pcq_rd_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      pcq_wr_reg      <= pcq_wr_next;
      pcq_rd_reg      <= pcq_rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_wr_reg] <= fetch_pc_reg;
  end

`ifdef IFQ_PERF_EN
  logic [2:0]  perf_inc;
  logic [31:0] perf_cnt [3];

  assign perf_inc[0] = redirect;
  assign perf_inc[1] = !instr_valid;
  assign perf_inc[2] = imem_rvalid && (redirect || dropping);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          perf_cnt[gi] <= '0;
        else if (perf_inc[gi] && (perf_cnt[gi] != 32'hFFFF_FFFF))
          perf_cnt[gi] <= perf_cnt[gi] + 32'd1;
      end
    end
  endgenerate

  assign perf_flush_cnt = perf_cnt[0];
  assign perf_empty_cnt = perf_cnt[1];
  assign perf_drop_cnt  = perf_cnt[2];
`endif

  a_credit: assert property (@(posedge clk) disable iff (rst)
    credit_sum <= (CW+1)'(DEPTH));
  a_drop: assert property (@(posedge clk) disable iff (rst)
    outstanding_reg >= drop_cnt_reg);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench: queue-based reference model of fetch, memory and buffering.
module tb_if_prefetch_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr, pc_incr;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_flush_cnt, perf_empty_cnt, perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr_valid(instr_valid), .instr(instr),
`ifdef IFQ_PERF_EN
    .pc_incr(pc_incr),
    .perf_flush_cnt(perf_flush_cnt), .perf_empty_cnt(perf_empty_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`else
    .pc_incr(pc_incr)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit dropped; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc_incr; } ent_t;

  req_t        infl[$];
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          cyc, lat_min, lat_max;
  int          n_checks = 0, n_fail = 0;
  int          m_flush, m_empty, m_drop;
  logic        obs_req, obs_valid, obs_rv, obs_acc;
  logic [31:0] obs_addr, obs_instr, obs_pc_incr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    infl.delete(); mq.delete();
    m_pc = 32'h0; cyc = 0;
    m_flush = 0; m_empty = 0; m_drop = 0;
  endtask

  // One clock: drive memory response, compare all outputs at negedge, advance model.
  task automatic step();
    bit   e_req, rv, acc, popv;
    ent_t h;
    req_t r;
    rv = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? memfn(infl[0].addr) : $urandom;
    @(negedge clk);
    e_req = !redirect && (mq.size() + infl.size() < DEPTH);
    h = '{32'h0, 32'h0};
    if (mq.size() > 0) h = mq[0];
    n_checks += 5;
    if (imem_req !== e_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, e_req);
    end
    if (imem_addr !== m_pc) begin
      n_fail++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
    end
    if (instr_valid !== (mq.size() > 0)) begin
      n_fail++; $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, mq.size() > 0);
    end
    if (instr !== h.instr) begin
      n_fail++; $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr, h.instr);
    end
    if (pc_incr !== h.pc_incr) begin
      n_fail++; $display("FAIL pc_incr cyc=%0d got=%h exp=%h", cyc, pc_incr, h.pc_incr);
    end
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
    obs_instr = instr; obs_pc_incr = pc_incr; obs_rv = rv;
    acc = e_req && imem_ready;
    obs_acc = acc;
    if (mq.size() == 0) m_empty++;
    if (redirect) begin
      m_flush++;
      if (rv) begin void'(infl.pop_front()); m_drop++; end
      foreach (infl[i]) begin r = infl[i]; r.dropped = 1'b1; infl[i] = r; end
      mq.delete();
      m_pc = redirect_pc;
    end else begin
      popv = (mq.size() > 0) && id_ready;
      if (popv) void'(mq.pop_front());
      if (rv) begin
        r = infl.pop_front();
        if (r.dropped) m_drop++;
        else mq.push_back('{memfn(r.addr), r.addr + 32'd4});
      end
      if (acc) begin
        infl.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    $display("cyc=%0d req=%b addr=%h rv=%b redir=%b valid=%b pc_incr=%h",
             cyc, obs_req, obs_addr, rv, redirect, obs_valid, obs_pc_incr);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0; id_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    if (instr !== 32'h0)      begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
    if (pc_incr !== 32'h0)    begin n_fail++; $display("FAIL reset_pc_incr got=%h exp=0", pc_incr); end
    if (imem_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [31:0] addrs[$], pcs[$];
    logic [31:0] exp_a [4];
    int first_acc = -1, first_val = -1;
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    lat_min = 1; lat_max = 1; imem_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_acc) begin addrs.push_back(obs_addr); if (first_acc < 0) first_acc = i; end
      if (obs_valid) begin pcs.push_back(obs_pc_incr); if (first_val < 0) first_val = i; end
    end
    n_checks++;
    if (first_val - first_acc != 2) begin
      n_fail++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_acc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= addrs.size() || addrs[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, (i < addrs.size()) ? addrs[i] : 32'hx, exp_a[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= pcs.size() || pcs[i] !== exp_a[i] + 32'd4) begin
        n_fail++; $display("FAIL stream_pc_incr[%0d] got=%h exp=%h", i, (i < pcs.size()) ? pcs[i] : 32'hx, exp_a[i] + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pcs[$];
    apply_reset();
    lat_min = 1; lat_max = 1; imem_ready = 1'b1; id_ready = 1'b0;
    repeat (8) step();
    n_checks += 3;
    if (obs_req !== 1'b0)          begin n_fail++; $display("FAIL stall_req got=%b exp=0", obs_req); end
    if (obs_pc_incr !== 32'h4)     begin n_fail++; $display("FAIL stall_head_pc got=%h exp=4", obs_pc_incr); end
    if (obs_instr !== memfn(32'h0)) begin n_fail++; $display("FAIL stall_head_instr got=%h exp=%h", obs_instr, memfn(32'h0)); end
    id_ready = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 10 && pcs.size() < 4; i++) begin
      step();
      if (obs_valid) pcs.push_back(obs_pc_incr);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= pcs.size() || pcs[i] !== 32'(4 * (i + 1))) begin
        n_fail++; $display("FAIL stall_drain[%0d] got=%h exp=%h", i, (i < pcs.size()) ? pcs[i] : 32'hx, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_redirect_latency();
    bit early = 0, seen = 0;
    logic [31:0] first_pc = 32'hx;
    apply_reset();
    lat_min = 3; lat_max = 3; imem_ready = 1'b1; id_ready = 1'b1;
    repeat (2) step();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (obs_valid) begin seen = 1; first_pc = obs_pc_incr; end
    end
    n_checks++;
    if (!seen || first_pc !== 32'h104 || early) begin
      n_fail++; $display("FAIL redirect_first_pc got=%h exp=00000104", first_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] tgt;
    apply_reset();
    lat_min = 1; lat_max = 1; imem_ready = 1'b1; id_ready = 1'b1;
    repeat (4) step();
    tgt = {$urandom, 2'b00};
    redirect = 1'b1; redirect_pc = tgt;
    step();
    n_checks++;
    if ({obs_rv, obs_valid} !== 2'b11) begin
      n_fail++; $display("FAIL coincident_setup got=%b exp=11", {obs_rv, obs_valid});
    end
    redirect = 1'b0; imem_ready = 1'b0;
    step();
    n_checks += 2;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL coincident_empty got=%b exp=0", obs_valid); end
    if (obs_addr !== tgt)   begin n_fail++; $display("FAIL coincident_pc got=%h exp=%h", obs_addr, tgt); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$], pcs[$];
    logic [31:0] exp_a [3];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    apply_reset();
    lat_min = 1; lat_max = 1; id_ready = 1'b1; imem_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_acc) addrs.push_back(obs_addr);
      if (obs_valid) pcs.push_back(obs_pc_incr);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= addrs.size() || addrs[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, (i < addrs.size()) ? addrs[i] : 32'hx, exp_a[i]);
      end
    end
    n_checks++;
    if (pcs.size() < 3 || pcs[2] !== 32'h4) begin
      n_fail++; $display("FAIL wrap_pc_incr got=%h exp=00000004", (pcs.size() >= 3) ? pcs[2] : 32'hx);
    end
  endtask

  task automatic test_reset_full();
    apply_reset();
    lat_min = 1; lat_max = 2; imem_ready = 1'b1; id_ready = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL rstfull_req got=%b exp=0", imem_req); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_valid got=%b exp=0", instr_valid); end
    if (instr !== 32'h0)      begin n_fail++; $display("FAIL rstfull_instr got=%h exp=0", instr); end
    if (pc_incr !== 32'h0)    begin n_fail++; $display("FAIL rstfull_pc_incr got=%h exp=0", pc_incr); end
    if (imem_addr !== 32'h0)  begin n_fail++; $display("FAIL rstfull_addr got=%h exp=0", imem_addr); end
`ifdef IFQ_PERF_EN
    n_checks++;
    if ({perf_flush_cnt, perf_empty_cnt, perf_drop_cnt} !== 96'h0) begin
      n_fail++; $display("FAIL rstfull_perf got=%h/%h/%h exp=0", perf_flush_cnt, perf_empty_cnt, perf_drop_cnt);
    end
`endif
    apply_reset();
    imem_ready = 1'b1; id_ready = 1'b1;
    step();
    n_checks++;
    if (obs_addr !== 32'h0 || obs_req !== 1'b1) begin
      n_fail++; $display("FAIL rstfull_restart got=%h/%b exp=00000000/1", obs_addr, obs_req);
    end
    repeat (4) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin lat_min = 1; lat_max = int'($urandom_range(4, 1)); end
      imem_ready = ($urandom_range(3, 0) != 0);
      id_ready   = ($urandom_range(9, 0) < 7);
      redirect   = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | {$urandom_range(3, 0), 2'b00})
                                               : {$urandom, 2'b00};
      step();
    end
    redirect = 1'b0;
`ifdef IFQ_PERF_EN
    n_checks += 3;
    if (perf_flush_cnt !== 32'(m_flush)) begin n_fail++; $display("FAIL perf_flush got=%0d exp=%0d", perf_flush_cnt, m_flush); end
    if (perf_empty_cnt !== 32'(m_empty)) begin n_fail++; $display("FAIL perf_empty got=%0d exp=%0d", perf_empty_cnt, m_empty); end
    if (perf_drop_cnt !== 32'(m_drop))   begin n_fail++; $display("FAIL perf_drop got=%0d exp=%0d", perf_drop_cnt, m_drop); end
`endif
  endtask

  initial begin
    model_reset();
    lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_coincident();
    test_wrap();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
